// File: rtl/iw_encoder_movwide_if.sv
// Handshake bundle for the LEGv8 MOVZ/MOVK wide-immediate encoder:
// start/value/rd request side and iw/iw_valid/iw_ready/iw_last/done emit side.
interface iw_encoder_movwide_if;
    logic        start;
    logic        start_ready;
    logic [63:0] value;
    logic [4:0]  rd;
    logic [31:0] iw;
    logic        iw_valid;
    logic        iw_ready;
    logic        iw_last;
    logic        done;

    modport master (
        output start,
        output value,
        output rd,
        output iw_ready,
        input  start_ready,
        input  iw,
        input  iw_valid,
        input  iw_last,
        input  done
    );

    modport slave (
        input  start,
        input  value,
        input  rd,
        input  iw_ready,
        output start_ready,
        output iw,
        output iw_valid,
        output iw_last,
        output done
    );
endinterface

// File: rtl/iw_encoder_movwide.sv
// Materializes a 64-bit constant into rd as a MOVZ followed by MOVK words.
// Define IW_ENCODER_SKIP_ZERO_EN to omit zero halfwords; otherwise all four are emitted.
module iw_encoder_movwide (
    input logic                   clock,
    input logic                   reset_n,
    iw_encoder_movwide_if.slave   bus
);

    localparam logic [8:0] OPC_MOVZ = 9'b110100101;
    localparam logic [8:0] OPC_MOVK = 9'b111100101;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EMIT = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic [1:0]  hw_q;
    logic        first_q;
    logic [63:0] value_q;
    logic [4:0]  rd_q;

    logic        accept;
    logic        xfer;
    logic        last_word;
    logic [1:0]  first_hw;
    logic [1:0]  next_hw;

    function automatic logic [15:0] halfword(input logic [63:0] v, input logic [1:0] hw);
        logic [15:0] h;
        case (hw)
            2'd0:    h = v[15:0];
            2'd1:    h = v[31:16];
            2'd2:    h = v[47:32];
            default: h = v[63:48];
        endcase
        return h;
    endfunction

`ifdef IW_ENCODER_SKIP_ZERO_EN
    logic [3:0] nz_q;
    logic [3:0] remain;

    function automatic logic [3:0] nonzero_mask(input logic [63:0] v);
        logic [3:0] m;
        for (int i = 0; i < 4; i++) begin
            m[i] = |v[16*i +: 16];
        end
        return m;
    endfunction

    // An all-zero mask maps to hw0 so that value==0 still yields one MOVZ.
    function automatic logic [1:0] lowest_set(input logic [3:0] m);
        logic [1:0] idx;
        if (m[0])      idx = 2'd0;
        else if (m[1]) idx = 2'd1;
        else if (m[2]) idx = 2'd2;
        else if (m[3]) idx = 2'd3;
        else           idx = 2'd0;
        return idx;
    endfunction

    // Nonzero halfwords strictly above the one currently presented.
    assign remain    = nz_q & (4'b1110 << hw_q);
    assign first_hw  = lowest_set(nonzero_mask(bus.value));
    assign last_word = (remain == 4'd0);
    assign next_hw   = lowest_set(remain);
`else
    assign first_hw  = 2'd0;
    assign last_word = (hw_q == 2'd3);
    assign next_hw   = hw_q + 2'd1;
`endif

    assign accept = (state == IDLE) && bus.start;
    assign xfer   = (state == EMIT) && bus.iw_ready;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (bus.start) state_nxt = EMIT;
            EMIT:    if (bus.iw_ready && last_word) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state   <= IDLE;
            hw_q    <= 2'd0;
            first_q <= 1'b0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                hw_q    <= first_hw;
                first_q <= 1'b1;
            end else if (xfer && !last_word) begin
                hw_q    <= next_hw;
                first_q <= 1'b0;
            end
        end
    end

    // Operand capture: only loaded on acceptance, so later input changes never leak in.
    always_ff @(posedge clock) begin
        if (accept) begin
            value_q <= bus.value;
            rd_q    <= bus.rd;
`ifdef IW_ENCODER_SKIP_ZERO_EN
            nz_q    <= nonzero_mask(bus.value);
`endif
        end
    end

    assign bus.start_ready = (state == IDLE);
    assign bus.iw_valid    = (state == EMIT);
    assign bus.iw_last     = (state == EMIT) && last_word;
    assign bus.done        = (state == DONE);
    assign bus.iw          = (state == EMIT)
                           ? {(first_q ? OPC_MOVZ : OPC_MOVK), hw_q, halfword(value_q, hw_q), rd_q}
                           : 32'd0;

endmodule

// File: doc/iw_encoder_movwide.md
IW_ENCODER_MOVWIDE -- requirements
Module: iw_encoder_movwide

Interface
REQ-001 No parameters; the instruction format is fixed 32-bit LEGv8 and the register index is fixed 5-bit.
REQ-002 One clock; reset is asynchronous and active-low.
REQ-003 clock  input  1  rising-edge clock for all state.
REQ-004 reset_n  input  1  asynchronous active-low reset.
REQ-005 start  input  1  request to encode value into rd; accepted only when start_ready=1.
REQ-006 start_ready  output  1  high only in IDLE.
REQ-007 value  input  64  constant to materialize; sampled at start acceptance.
REQ-008 rd  input  5  destination register; sampled at start acceptance.
REQ-009 iw  output  32  emitted MOVZ/MOVK instruction word.
REQ-010 iw_valid  output  1  iw holds a valid word.
REQ-011 iw_ready  input  1  downstream accepts iw; a transfer occurs when iw_valid && iw_ready.
REQ-012 iw_last  output  1  high with the final word of the sequence.
REQ-013 done  output  1  one-cycle pulse after the final transfer.

Function
REQ-014 FSM states are IDLE, EMIT and DONE; the reset state is IDLE.
REQ-015 IDLE->EMIT on start; value and rd are latched in that cycle; iw_valid rises the next cycle.
REQ-016 MOVZ encoding: iw = {9'b110100101, hw[1:0], imm16, rd}. MOVK encoding: iw = {9'b111100101, hw[1:0], imm16, rd}.
REQ-017 imm16 = value[16*hw+15 : 16*hw].
REQ-018 The first word is always MOVZ.
REQ-019 The first word uses the lowest-index nonzero halfword, or hw=0 when value==0.
REQ-020 Subsequent words are MOVK, one per remaining nonzero halfword, in ascending hw order.
REQ-021 Sequence length is 1 to 4 words; iw_last is high exactly on the last word.
REQ-022 While iw_valid && !iw_ready, iw, iw_valid and iw_last hold stable.
REQ-023 After each transfer the next word is presented the following cycle, with no bubble.
REQ-024 EMIT->DONE on the transfer of the iw_last word.
REQ-025 In DONE, done=1 and iw_valid=0 for exactly one cycle, then the FSM returns to IDLE.
REQ-026 start while not in IDLE is ignored; the latched value and rd are unaffected.
REQ-027 A change on value or rd after acceptance does not affect the sequence in flight.
REQ-028 Back-to-back operation: start asserted in the cycle after done is accepted.

Reset
REQ-029 reset_n=0 forces IDLE immediately, independent of clock, with these output values: iw_valid=0, iw_last=0, done=0, iw=0, start_ready=1.
REQ-030 Reset mid-sequence abandons the remaining words; no partial word is emitted after reset deasserts.

Configuration
REQ-031 The optimization is controlled by macro IW_ENCODER_SKIP_ZERO_EN.
REQ-032 With IW_ENCODER_SKIP_ZERO_EN defined, the block uses the zero-halfword skipping of REQ-019 and REQ-020.
REQ-033 Without IW_ENCODER_SKIP_ZERO_EN, the block always emits 4 words, zero halfwords included: MOVZ hw0, then MOVK hw1, hw2, hw3.

Verification
REQ-034 value=0, rd=3, iw_ready=1 -> single word 0xD2800003 with iw_last=1, done one cycle later (4 words with the macro undefined).
REQ-035 value=0x0000_1234_0000_5678, rd=1 (macro defined) -> 0xD28ACF01, then 0xF2C24681 with iw_last=1.
REQ-036 value=0xFFFF_FFFF_FFFF_FFFF, rd=31 -> 0xD29FFFFF, 0xF2BFFFFF, 0xF2DFFFFF, 0xF2FFFFFF on consecutive cycles.
REQ-037 Same stimulus as REQ-036 with iw_ready low for 3 cycles on word 2 -> 0xF2BFFFFF is held stable and no word is dropped or duplicated.
REQ-038 reset_n pulsed low during word 2 of REQ-036 -> iw_valid=0 immediately, then a new start with value=0x5 and rd=0 yields 0xD28000A0.
